// File: rtl/swt16_hazard_unit.sv
// Pipeline hazard control for swt16: per-stage destination scoreboard, RAW detection at decode,
// stall/bubble/flush generation and hazard-stall counting. Define SWT16_FWD_EN to enable forwarding.
module swt16_hazard_unit #(
  parameter  int REG_IDX_WIDTH = 4,
  parameter  int NUM_STAGES    = 3,
  parameter  int CNT_WIDTH     = 16,
  localparam int SEL_WIDTH     = $clog2(NUM_STAGES + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_dc_valid,
  input  logic [REG_IDX_WIDTH-1:0] in_dc_src1_idx,
  input  logic [REG_IDX_WIDTH-1:0] in_dc_src2_idx,
  input  logic                     in_dc_src1_used,
  input  logic                     in_dc_src2_used,
  input  logic [REG_IDX_WIDTH-1:0] in_dc_dst_idx,
  input  logic                     in_dc_writes_reg,
  input  logic                     in_dc_is_load,
  input  logic                     in_set_pc,
  input  logic                     in_ext_stall,
  output logic                     out_stall,
  output logic                     out_bubble,
  output logic                     out_flush,
  output logic [SEL_WIDTH-1:0]     out_fwd_src1_sel,
  output logic [SEL_WIDTH-1:0]     out_fwd_src2_sel,
  output logic [CNT_WIDTH-1:0]     out_stall_count
);

  typedef struct packed {
    logic                     valid;
    logic [REG_IDX_WIDTH-1:0] dst;
    logic                     is_load;
  } sb_entry_t;

  sb_entry_t              sb_reg [NUM_STAGES];
  logic [CNT_WIDTH-1:0]   cnt_reg;

  logic [NUM_STAGES-1:0]  match1;
  logic [NUM_STAGES-1:0]  match2;
  logic                   hazard;
  logic [SEL_WIDTH-1:0]   sel1;
  logic [SEL_WIDTH-1:0]   sel2;
  logic                   stall_raw;
  logic                   bubble_raw;
  logic                   flush_raw;
  logic                   issue;
  sb_entry_t              new_entry;

  // WB entries still match: the register file has no write-through.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_match
      assign match1[gi] = in_dc_src1_used & sb_reg[gi].valid & (sb_reg[gi].dst == in_dc_src1_idx);
      assign match2[gi] = in_dc_src2_used & sb_reg[gi].valid & (sb_reg[gi].dst == in_dc_src2_idx);
    end
  endgenerate

`ifdef SWT16_FWD_EN
  logic haz1;
  logic haz2;

  // Descending scan so the youngest (lowest index) match is the last one written.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    sel1 = '0;
    sel2 = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (match1[i]) begin
        sel1 = SEL_WIDTH'(i + 1);
        haz1 = sb_reg[i].is_load && (i < 2);
      end
      if (match2[i]) begin
        sel2 = SEL_WIDTH'(i + 1);
        haz2 = sb_reg[i].is_load && (i < 2);
      end
    end
    hazard = haz1 | haz2;
  end
`else
  always_comb begin
    sel1   = '0;
    sel2   = '0;
    hazard = (|match1) | (|match2);
  end
`endif

  assign stall_raw  = in_ext_stall | (hazard & in_dc_valid & ~in_set_pc);
  assign bubble_raw = hazard & in_dc_valid & ~in_set_pc & ~in_ext_stall;
  assign flush_raw  = in_set_pc & ~in_ext_stall;

  // While reset is asserted the outputs present the empty-scoreboard view.
  assign out_stall        = reset ? stall_raw  : 1'b0;
  assign out_bubble       = reset ? bubble_raw : 1'b0;
  assign out_flush        = reset ? flush_raw  : in_set_pc;
  assign out_fwd_src1_sel = reset ? sel1 : '0;
  assign out_fwd_src2_sel = reset ? sel2 : '0;
  assign out_stall_count  = cnt_reg;

  assign issue = in_dc_valid & ~stall_raw & ~flush_raw;

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = issue & in_dc_writes_reg;
    new_entry.dst     = in_dc_writes_reg ? in_dc_dst_idx : '0;
    new_entry.is_load = in_dc_writes_reg & in_dc_is_load;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGES; i++) sb_reg[i] <= '0;
      cnt_reg <= '0;
    end else if (!in_ext_stall) begin
      sb_reg[0] <= new_entry;
      for (int i = 1; i < NUM_STAGES; i++) sb_reg[i] <= sb_reg[i-1];
      if (bubble_raw && (cnt_reg != {CNT_WIDTH{1'b1}}))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_swt16_hazard_unit.sv
// Directed bench for swt16_hazard_unit; expectations follow SWT16_FWD_EN when it is defined.
module tb_swt16_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       dc_valid, s1_used, s2_used, writes_reg, is_load, set_pc, ext_stall;
  logic [3:0] s1_idx, s2_idx, dst_idx;

  logic        stall0, bubble0, flush0;
  logic [1:0]  sel1_0, sel2_0;
  logic [15:0] cnt0;
  logic        stall1, bubble1, flush1;
  logic [1:0]  sel1_1, sel2_1;
  logic [1:0]  cnt1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;

`ifdef SWT16_FWD_EN
  localparam int LU_N = 2, LU_SEL = 3, EXT_N = 0, EXT_SEL = 1;
`else
  localparam int LU_N = 3, LU_SEL = 0, EXT_N = 3, EXT_SEL = 0;
`endif

  always #5 clock = ~clock;

  swt16_hazard_unit #(.REG_IDX_WIDTH(4), .NUM_STAGES(3), .CNT_WIDTH(16)) u0 (
    .clock(clock), .reset(reset), .in_dc_valid(dc_valid),
    .in_dc_src1_idx(s1_idx), .in_dc_src2_idx(s2_idx),
    .in_dc_src1_used(s1_used), .in_dc_src2_used(s2_used),
    .in_dc_dst_idx(dst_idx), .in_dc_writes_reg(writes_reg), .in_dc_is_load(is_load),
    .in_set_pc(set_pc), .in_ext_stall(ext_stall),
    .out_stall(stall0), .out_bubble(bubble0), .out_flush(flush0),
    .out_fwd_src1_sel(sel1_0), .out_fwd_src2_sel(sel2_0), .out_stall_count(cnt0)
  );

  swt16_hazard_unit #(.REG_IDX_WIDTH(4), .NUM_STAGES(3), .CNT_WIDTH(2)) u1 (
    .clock(clock), .reset(reset), .in_dc_valid(dc_valid),
    .in_dc_src1_idx(s1_idx), .in_dc_src2_idx(s2_idx),
    .in_dc_src1_used(s1_used), .in_dc_src2_used(s2_used),
    .in_dc_dst_idx(dst_idx), .in_dc_writes_reg(writes_reg), .in_dc_is_load(is_load),
    .in_set_pc(set_pc), .in_ext_stall(ext_stall),
    .out_stall(stall1), .out_bubble(bubble1), .out_flush(flush1),
    .out_fwd_src1_sel(sel1_1), .out_fwd_src2_sel(sel2_1), .out_stall_count(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic au, input logic [3:0] b,
                       input logic bu, input logic [3:0] d, input logic wr, input logic ld,
                       input logic spc, input logic ext);
    dc_valid = v; s1_idx = a; s1_used = au; s2_idx = b; s2_used = bu;
    dst_idx = d; writes_reg = wr; is_load = ld; set_pc = spc; ext_stall = ext;
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic issue_producer(input logic [3:0] d, input logic ld);
    drive(1, 0, 0, 0, 0, d, 1, ld, 0, 0);
    chk("producer_stall", stall0, 0);
    tick();
  endtask

  // Reader already driven: expect n hazard cycles, then issue with the given selects.
  task automatic expect_stalls(input string tag, input int n, input logic [1:0] e1, input logic [1:0] e2);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_stall"}, stall0, 1);
      chk({tag, "_bubble"}, bubble0, 1);
      tick();
      exp_cnt++;
    end
    chk({tag, "_issue_stall"}, stall0, 0);
    chk({tag, "_issue_bubble"}, bubble0, 0);
    chk({tag, "_sel1"}, sel1_0, 32'(e1));
    chk({tag, "_sel2"}, sel2_0, 32'(e2));
    chk({tag, "_count"}, cnt0, 32'(exp_cnt));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input high
    reset = 1'b0;
    drive(1, 4'hf, 1, 4'hf, 1, 4'hf, 1, 1, 1, 1);
    tick(); tick();
    chk("rst_stall", stall0, 0);
    chk("rst_bubble", bubble0, 0);
    chk("rst_flush", flush0, 1);
    chk("rst_sel1", sel1_0, 0);
    chk("rst_sel2", sel2_0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_count_sat", cnt1, 0);
    reset = 1'b1;
    drive(1, 4'hf, 1, 4'hf, 1, 0, 0, 0, 0, 0);
    chk("post_rst_stall", stall0, 0);
    chk("post_rst_sel1", sel1_0, 0);
    tick();
    idle(3);

    // ADD r3 then dependent reader of r3
    issue_producer(4'd3, 0);
    drive(1, 4'd3, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef SWT16_FWD_EN
    chk("fwd_ex_stall", stall0, 0);
    chk("fwd_ex_sel1", sel1_0, 1);
    tick();
    chk("fwd_mem_stall", stall0, 0);
    chk("fwd_mem_sel1", sel1_0, 2);
    tick();
`else
    expect_stalls("raw", 3, 0, 0);
`endif
    idle(3);

    // Load-use through src2
    issue_producer(4'd5, 1);
    drive(1, 0, 0, 4'd5, 1, 0, 0, 0, 0, 0);
    expect_stalls("loaduse", LU_N, 0, 2'(LU_SEL));
    idle(3);

    // Flush wins over hazard; flushed writer never enters the scoreboard
    issue_producer(4'd7, 0);
    drive(1, 4'd7, 1, 0, 0, 4'd9, 1, 0, 1, 0);
    chk("flush_flush", flush0, 1);
    chk("flush_stall", stall0, 0);
    chk("flush_bubble", bubble0, 0);
    tick();
    chk("flush_count", cnt0, 32'(exp_cnt));
    drive(1, 4'd9, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_killed_stall", stall0, 0);
    chk("flush_killed_sel1", sel1_0, 0);
    tick();
    idle(3);

    // External stall during a hazard freezes scoreboard and counter
    issue_producer(4'd4, 0);
    drive(1, 4'd4, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      chk("ext_stall", stall0, 1);
      chk("ext_bubble", bubble0, 0);
      chk("ext_sel1", sel1_0, 32'(EXT_SEL));
      tick();
    end
    chk("ext_count", cnt0, 32'(exp_cnt));
    drive(1, 4'd4, 1, 0, 0, 0, 0, 0, 1, 1);
    chk("ext_setpc_flush", flush0, 0);
    chk("ext_setpc_stall", stall0, 1);
    tick();
    drive(1, 4'd4, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_stalls("ext_release", EXT_N, 2'(EXT_SEL), 0);
    idle(3);

    // Same destination twice: the younger ALU result shadows the older load
    issue_producer(4'd6, 1);
    issue_producer(4'd6, 0);
    drive(1, 4'd6, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef SWT16_FWD_EN
    expect_stalls("dup", 0, 1, 0);
`else
    expect_stalls("dup", 3, 0, 0);
`endif
    idle(3);

    // Enough load-use stalls to saturate the 2-bit counter
    for (int r = 0; r < 3; r++) begin
      issue_producer(4'd2, 1);
      drive(1, 4'd2, 1, 0, 0, 0, 0, 0, 0, 0);
      expect_stalls("sat", LU_N, 2'(LU_SEL), 0);
      idle(3);
    end
    chk("sat_count", cnt1, 3);
    chk("final_count", cnt0, 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
